// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic [1:0] {
    PWM_SEL_IDLE = 2'b00,
    PWM_SEL_CMP  = 2'b01,
    PWM_SEL_TOP  = 2'b10,
    PWM_SEL_CNT  = 2'b11
  } pwm_sel_e;

  localparam int unsigned PWM_WIDTH    = 16;
  localparam int unsigned PWM_CHANNELS = 4;

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: shadow compare, active compare and the output comparator.
module pwm_channel #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic             upd_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             out_o
);

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;

  // The update takes the shadow as it was before any same-cycle write.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (upd_i) active_d = shadow_q;
    if (wr_i)  shadow_d = d_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign out_o = cnt_i < active_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, shadowed top, CHANNELS compare channels.
// Optional center-aligned counting is enabled by defining PWM_CENTER_EN.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned  WIDTH    = PWM_WIDTH,
  parameter int unsigned  CHANNELS = PWM_CHANNELS,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
`ifdef PWM_CENTER_EN
  input  logic                center,
`endif
  input  logic [1:0]          sel,
  input  logic [CH_W-1:0]     ch,
  input  logic [WIDTH-1:0]    d,
  output logic [WIDTH-1:0]    cnt,
  output logic [WIDTH-1:0]    top,
  output logic [CHANNELS-1:0] out,
  output logic                period_end
);

  pwm_sel_e sel_e;
  logic load, wrap, upd;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] top_sh_q, top_sh_d;
  logic [CHANNELS-1:0] wr;

  assign sel_e = pwm_sel_e'(sel);
  assign load  = sel_e == PWM_SEL_CNT;
  assign upd   = en & ~load & wrap;

`ifdef PWM_CENTER_EN
  logic dir_q, dir_d;  // 1 = counting down

  always_comb begin
    if (!center)          wrap = cnt_q >= top_q;
    else if (top_q == '0) wrap = 1'b1;
    else                  wrap = dir_q && (cnt_q == '0);
  end

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (load) begin
      cnt_d = d;
    end else if (en) begin
      if (!center) begin
        dir_d = 1'b0;
        cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
      end else if (top_q == '0) begin
        cnt_d = '0;
        dir_d = 1'b0;
      end else if (!dir_q) begin
        // At or above top while rising: turn around without exceeding the loaded value.
        if (cnt_q >= top_q) begin
          cnt_d = cnt_q - WIDTH'(1);
          dir_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else if (cnt_q == '0) begin
        cnt_d = WIDTH'(1);
        dir_d = 1'b0;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir_q <= 1'b0;
    else     dir_q <= dir_d;
  end
`else
  assign wrap = cnt_q >= top_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)    cnt_d = d;
    else if (en) cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
  end
`endif

  always_comb begin
    top_d    = top_q;
    top_sh_d = top_sh_q;
    if (upd) top_d = top_sh_q;
    if (en && sel_e == PWM_SEL_TOP) top_sh_d = d;
  end

  always_comb begin
    wr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr[i] = en && (sel_e == PWM_SEL_CMP) && (ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      top_q    <= '0;
      top_sh_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      top_q    <= top_d;
      top_sh_q <= top_sh_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .wr_i  (wr[i]),
      .upd_i (upd),
      .d_i   (d),
      .cnt_i (cnt_q),
      .out_o (out[i])
    );
  end

  assign cnt        = cnt_q;
  assign top        = top_q;
  // Reset must clear period_end even while en is held high.
  assign period_end = upd & ~rst;

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator, the parametrised successor of the single-channel counter/compare PWM. It has one shared period counter with a programmable top value and CHANNELS independent compare channels. Top and compare writes go to shadow registers and take effect only at a period boundary, so changes never glitch an output. It sits between the register-write path (`sel`/`d` style) and the pin drivers.

## Interface
- WIDTH, 16, counter/top/compare width in bits
- CHANNELS, 4, number of compare channels (≥1)
- CH_W, max(1,$clog2(CHANNELS)), channel index width (derived, not overridden)

- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- en  input  1  counter run enable; low = counter and outputs freeze
- sel  input  2  command: 00 idle, 01 write compare, 10 write top, 11 load counter
- ch  input  CH_W  target channel for sel=01; values ≥ CHANNELS ignored
- d  input  WIDTH  write data
- cnt  output  WIDTH  current counter value
- top  output  WIDTH  active top value
- out  output  CHANNELS  PWM outputs, out[i] = cnt < active cmp[i]
- period_end  output  1  high in the last cycle of a period (the update cycle)

## Operation
- Reset: cnt=0, shadow/active top=0, all shadow/active cmp=0, out=0, period_end=0, direction=up.
- sel=01: shadow_cmp[ch] <= d. sel=10: shadow_top <= d. Active values are unchanged.
- sel=11: cnt <= d immediately, even when en=0. This is the only command that acts when en=0. No shadow transfer occurs in that cycle. Direction is unchanged.
- Edge-aligned mode, en=1, sel≠11:
  - If cnt < top: cnt+1.
  - Otherwise cnt <= 0. This cycle is the update cycle: active top and all active cmp load from their shadows.
- The update uses shadow contents *before* any write in the same cycle. A write in the update cycle takes effect at the following boundary.
- period_end = en & (sel≠11) & update-cycle condition. It is combinational from registered state and inputs.
- out is combinational: cnt < active_cmp[i], unsigned compare.
  - cmp=0 gives constant 0.
  - cmp>top gives constant 1.
- top=0: cnt stays 0, and every enabled cycle is an update cycle.
- A counter loaded above top wraps to 0 on the next enabled edge, and that edge is an update.

## Timing
- Write latency: shadow visible 1 cycle after the sel edge. Active value visible after the next update edge.
- Edge-aligned period = top+1 cycles. The high time of out[i] is min(cmp[i], top+1) cycles.
- out and period_end have zero-cycle latency relative to cnt.
- en low: all state is held. period_end=0. out is still driven from the held cnt.
- rst asserted mid-period: all outputs are forced to reset values asynchronously. Counting resumes from 0 on the first enabled edge after deassertion.

## Configuration
- PWM_CENTER_EN defined:
  - Adds input `center` (1 bit, sampled every cycle) and an internal direction flag.
  - With center=1, the counter counts up to top, then down to 0, then up again. Direction flips on the edge where cnt reaches top while counting up, or reaches 0 while counting down.
  - The update cycle is cnt==0 while counting down (or top==0). Period = 2·top cycles, or 1 cycle if top=0.
  - With center=0, behaviour is identical to edge-aligned mode, and direction is forced to up.
  - sel=11 while counting down keeps counting down. A value above top while counting up flips direction on the next enabled edge without exceeding the loaded value.
- Not defined: no `center` port, no direction flag, edge-aligned only.

## Structure
- Package pwm_pkg holds:
  - enum pwm_sel_e {PWM_SEL_IDLE, PWM_SEL_CMP, PWM_SEL_TOP, PWM_SEL_CNT}
  - the default WIDTH and CHANNELS localparams
- Sub-module pwm_channel (one instance per channel, generated). It holds the shadow cmp, the active cmp and the compare. Its inputs are write strobe, update strobe, d and cnt; its output is out.
- Counter, top shadow/active and direction logic live in pwm_multi.

## Test plan
- Reset then top=4, cmp[0]=2, en=1 → cnt 0,1,2,3,4,0…; out[0] pattern 1,1,0,0,0; period_end high only at cnt=4.
- Write cmp[1]=3 mid-period (cnt=1, top=4) → out[1] unchanged until the cycle after cnt=4, then high for 3 cycles per period.
- Write top=7 in the update cycle (cnt=4, top=4) → next period still ends at 4; the following period ends at 7.
- cmp[2]=0 and cmp[3]=9 with top=4 → out[2] constant 0, out[3] constant 1. sel=11 with d=10 → cnt 10, then 0 with period_end=1.
- en=0 for 3 cycles at cnt=2 → cnt, out hold, period_end=0. Assert rst at cnt=3 → cnt=0, out=0 immediately, without waiting for a clock edge.
- PWM_CENTER_EN, center=1, top=3, cmp[0]=2 → cnt 0,1,2,3,2,1,0,1…; out[0]=1 only while cnt<2; update/period_end at cnt=0 while counting down.
